axis_mem_port: RTL and testbench

AXIS_MEM_PORT -- requirements
Module: axis_mem_port

---
 rtl/proc_bridge_pkg.sv | 25 ++
 rtl/resp_fifo.sv | 46 ++++
 rtl/axis_mem_port.sv | 143 ++++++++++++++
 tb/tb_axis_mem_port.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_bridge_pkg.sv
// Shared definitions for the AXI-stream to memory-port bridge: beat/address
// widths, header layout and the controller state encoding.
package proc_bridge_pkg;
    localparam int BEAT_W       = 128;
    localparam int ADDR_W       = 27;
    localparam int HDR_WEN_BIT  = 0;
    localparam int HDR_LEN_LSB  = 1;
    localparam int HDR_ADDR_LSB = HDR_LEN_LSB + ADDR_W;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [ADDR_W-1:0] stream_length;
        logic              wen;
    } channel_update_t;

    typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_READ} state_e;

    function automatic channel_update_t decode_hdr(input logic [BEAT_W-1:0] d);
        channel_update_t cu;
        cu.wen           = d[HDR_WEN_BIT];
        cu.stream_length = d[HDR_LEN_LSB +: ADDR_W];
        cu.addr          = d[HDR_ADDR_LSB +: ADDR_W];
        return cu;
    endfunction
endpackage

// File: rtl/resp_fifo.sv
// Synchronous FIFO holding read-return beats (payload plus last flag).
module resp_fifo #(
    parameter int WIDTH = 129,
    parameter int DEPTH = 8
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         din_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wp_q, rp_q;
    logic [AW:0]      cnt_q;
    logic             do_push, do_pop;

    assign full_o  = (cnt_q == FULL_CNT);
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign dout_o  = mem_q[rp_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            wp_q  <= wp_q + AW'(do_push);
            rp_q  <= rp_q + AW'(do_pop);
            cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk_in) begin
        if (do_push) mem_q[wp_q] <= din_i;
    end
endmodule

// File: rtl/axis_mem_port.sv
// Bridges a header-framed AXI-stream request channel onto a simple memory
// command port, returning read data as bursts on a response stream.
module axis_mem_port
    import proc_bridge_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic [BEAT_W-1:0] req_axis_data,
    input  logic              req_axis_tuser,
    input  logic              req_axis_valid,
    output logic              req_axis_ready,
    output logic              mem_cmd_valid,
    input  logic              mem_cmd_ready,
    output logic              mem_cmd_wen,
    output logic [ADDR_W-1:0] mem_cmd_addr,
    output logic [BEAT_W-1:0] mem_cmd_wdata,
    input  logic              mem_rdata_valid,
    input  logic [BEAT_W-1:0] mem_rdata,
    output logic [BEAT_W-1:0] resp_axis_data,
    output logic              resp_axis_valid,
    input  logic              resp_axis_ready,
    output logic              resp_axis_tuser,
    output logic [7:0]        err_count_out
);
    localparam int CW = $clog2(FIFO_DEPTH);
    localparam logic [CW+1:0] DEPTH_CNT = (CW+2)'(FIFO_DEPTH);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d, cnt_q, cnt_d;
    logic [CW:0]       outst_q, outst_d;
    logic [7:0]        err_q, err_d;
    logic [FIFO_DEPTH-1:0] lf_q;
    logic [CW-1:0]     lf_wp_q, lf_rp_q;

    channel_update_t   hdr;
    logic              hdr_take, proto_err, cmd_fire, rd_issue, rd_push, stray, credit_ok;
    logic [CW:0]       f_count;
    logic              f_full, f_empty;
    logic [BEAT_W:0]   f_dout;
    logic [8:0]        err_sum;

    assign hdr       = decode_hdr(req_axis_data);
    // Outstanding reads plus buffered beats must fit the FIFO, so returns never overflow it.
    assign credit_ok = ({1'b0, outst_q} + {1'b0, f_count}) < DEPTH_CNT && !f_full;

    always_comb begin
        req_axis_ready = 1'b0;
        mem_cmd_valid  = 1'b0;
        mem_cmd_wen    = 1'b0;
        mem_cmd_wdata  = '0;
        mem_cmd_addr   = addr_q;
        hdr_take       = 1'b0;
        proto_err      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_axis_ready = 1'b1;
                hdr_take       = req_axis_valid && req_axis_tuser;
                proto_err      = req_axis_valid && !req_axis_tuser;
            end
            ST_WRITE: begin
                if (req_axis_tuser) begin
                    req_axis_ready = 1'b1;
                    hdr_take       = req_axis_valid;
                    proto_err      = req_axis_valid;
                end else begin
                    req_axis_ready = mem_cmd_ready;
                    mem_cmd_valid  = req_axis_valid;
                    mem_cmd_wen    = 1'b1;
                    mem_cmd_wdata  = req_axis_data;
                end
            end
            ST_READ: mem_cmd_valid = credit_ok;
            default: ;
        endcase
    end

    assign cmd_fire = mem_cmd_valid && mem_cmd_ready;
    assign rd_issue = cmd_fire && (state_q == ST_READ);
    assign rd_push  = mem_rdata_valid && (outst_q != '0);
    assign stray    = mem_rdata_valid && (outst_q == '0);
    assign outst_d  = outst_q + (CW+1)'(rd_issue) - (CW+1)'(rd_push);
    assign err_sum  = {1'b0, err_q} + 9'(proto_err) + 9'(stray);
    assign err_d    = err_sum[8] ? 8'hFF : err_sum[7:0];

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        if (hdr_take) begin
            addr_d  = hdr.addr;
            cnt_d   = hdr.stream_length;
            if (hdr.stream_length == '0) state_d = ST_IDLE;
            else                         state_d = hdr.wen ? ST_WRITE : ST_READ;
        end else if (cmd_fire) begin
            addr_d = addr_q + ADDR_W'(1);
            cnt_d  = cnt_q - ADDR_W'(1);
            if (cnt_q == ADDR_W'(1)) state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            outst_q <= '0;
            err_q   <= '0;
            lf_q    <= '0;
            lf_wp_q <= '0;
            lf_rp_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            outst_q <= outst_d;
            err_q   <= err_d;
            if (rd_issue) begin
                lf_q[lf_wp_q] <= (cnt_q == ADDR_W'(1));
                lf_wp_q       <= lf_wp_q + CW'(1);
            end
            if (rd_push) lf_rp_q <= lf_rp_q + CW'(1);
        end
    end

    resp_fifo #(.WIDTH(BEAT_W+1), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .push_i  (rd_push),
        .din_i   ({lf_q[lf_rp_q], mem_rdata}),
        .pop_i   (resp_axis_valid && resp_axis_ready),
        .dout_o  (f_dout),
        .full_o  (f_full),
        .empty_o (f_empty),
        .count_o (f_count)
    );

    assign resp_axis_valid = !f_empty;
    assign resp_axis_tuser = f_dout[BEAT_W] && !f_empty;
    assign resp_axis_data  = f_dout[BEAT_W-1:0];
    assign err_count_out   = err_q;
endmodule

// File: tb/tb_axis_mem_port.sv
// Directed bench: queue-based model of commands, memory returns and responses,
// checked every cycle, plus hand-computed expectations per scenario.
module tb_axis_mem_port;
    localparam int DEPTH = 8;

    logic         clk_in = 1'b0, rst_in = 1'b0;
    logic [127:0] req_axis_data = '0;
    logic         req_axis_tuser = 1'b0, req_axis_valid = 1'b0, req_axis_ready;
    logic         mem_cmd_valid, mem_cmd_ready = 1'b1, mem_cmd_wen;
    logic [26:0]  mem_cmd_addr;
    logic [127:0] mem_cmd_wdata;
    logic         mem_rdata_valid = 1'b0;
    logic [127:0] mem_rdata = '0;
    logic [127:0] resp_axis_data;
    logic         resp_axis_valid, resp_axis_ready = 1'b1, resp_axis_tuser;
    logic [7:0]   err_count_out;

    axis_mem_port #(.FIFO_DEPTH(DEPTH)) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .req_axis_data(req_axis_data), .req_axis_tuser(req_axis_tuser),
        .req_axis_valid(req_axis_valid), .req_axis_ready(req_axis_ready),
        .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready),
        .mem_cmd_wen(mem_cmd_wen), .mem_cmd_addr(mem_cmd_addr), .mem_cmd_wdata(mem_cmd_wdata),
        .mem_rdata_valid(mem_rdata_valid), .mem_rdata(mem_rdata),
        .resp_axis_data(resp_axis_data), .resp_axis_valid(resp_axis_valid),
        .resp_axis_ready(resp_axis_ready), .resp_axis_tuser(resp_axis_tuser),
        .err_count_out(err_count_out)
    );

    always #5 clk_in = ~clk_in;
    int cyc = 0;
    always @(posedge clk_in) cyc++;

    typedef struct { logic wen; logic [26:0] addr; logic [127:0] wdata; logic last; } cmd_t;
    typedef struct { int due; logic [127:0] data; logic last; logic stray; } ret_t;
    typedef struct { logic [127:0] data; logic last; } rsp_t;
    cmd_t exp_cmd[$];
    ret_t mq[$];
    rsp_t exp_resp[$];

    int nchk = 0, nerr = 0;
    int nrd = 0, n_wr = 0, nresp = 0, n_last = 0, last_idx = -1, stray_seen = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [127:0] mdata(input logic [26:0] a);
        return {32'hDEADBEEF, 69'd0, a};
    endfunction

    function automatic logic [127:0] hdr(input logic [26:0] a, input logic [26:0] l, input logic w);
        logic [127:0] h;
        h = '0;
        h[54:0] = {a, l, w};
        return h;
    endfunction

    // Memory model drives returns at negedge; the monitor samples 1ns before the next rising edge.
    always @(negedge clk_in) begin
        ret_t r;
        rsp_t e;
        cmd_t c;
        int   outst;
        if (mq.size() > 0 && mq[0].due <= cyc + 1) begin
            mem_rdata_valid = 1'b1;
            mem_rdata       = mq[0].data;
        end else begin
            mem_rdata_valid = 1'b0;
            mem_rdata       = '0;
        end
        #4;
        if (!rst_in) begin
            if (mem_rdata_valid && mq.size() > 0) void'(mq.pop_front());
        end else begin
            chk("resp_valid", 128'(resp_axis_valid), 128'(exp_resp.size() > 0));
            if (resp_axis_valid && resp_axis_ready && exp_resp.size() > 0) begin
                e = exp_resp.pop_front();
                nresp++;
                chk("resp_data", resp_axis_data, e.data);
                chk("resp_tuser", 128'(resp_axis_tuser), 128'(e.last));
                if (resp_axis_tuser) begin n_last++; last_idx = nresp; end
            end
            if (mem_cmd_valid && mem_cmd_ready) begin
                if (exp_cmd.size() == 0) begin
                    nchk++; nerr++;
                    $display("FAIL unexpected_cmd: got addr %0h wen %0b expected none", mem_cmd_addr, mem_cmd_wen);
                end else begin
                    c = exp_cmd.pop_front();
                    chk("cmd_wen", 128'(mem_cmd_wen), 128'(c.wen));
                    chk("cmd_addr", 128'(mem_cmd_addr), 128'(c.addr));
                    chk("cmd_wdata", mem_cmd_wdata, c.wdata);
                    if (!mem_cmd_wen) begin
                        nrd++;
                        mq.push_back('{cyc + 4, mdata(mem_cmd_addr), c.last, 1'b0});
                    end else n_wr++;
                end
            end
            if (mem_rdata_valid && mq.size() > 0) begin
                r = mq.pop_front();
                if (r.stray) stray_seen++;
                else exp_resp.push_back('{r.data, r.last});
            end
            outst = 0;
            foreach (mq[i]) if (!mq[i].stray) outst++;
            nchk++;
            if (outst + exp_resp.size() > DEPTH) begin
                nerr++;
                $display("FAIL credit: got %0d in flight expected at most %0d", outst + exp_resp.size(), DEPTH);
            end
        end
    end

    task automatic send(input logic tu, input logic [127:0] d);
        bit acc;
        acc = 0;
        req_axis_valid = 1'b1; req_axis_tuser = tu; req_axis_data = d;
        for (int i = 0; i < 500 && !acc; i++) begin
            #4;
            acc = req_axis_ready;
            @(negedge clk_in);
        end
        req_axis_valid = 1'b0; req_axis_tuser = 1'b0;
        if (!acc) begin nchk++; nerr++; $display("FAIL send_timeout: got no ready expected ready"); end
    endtask

    task automatic exp_burst(input logic w, input logic [26:0] a, input int len, input logic [127:0] db);
        for (int i = 0; i < len; i++)
            exp_cmd.push_back('{w, a + 27'(i), w ? db + 128'(i) : 128'd0, i == len - 1});
    endtask

    task automatic wait_quiet(input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            if (exp_cmd.size() == 0 && mq.size() == 0 && exp_resp.size() == 0) break;
            @(negedge clk_in);
        end
        chk("quiet_timeout", 128'(i < budget), 128'(1));
        repeat (2) @(negedge clk_in);
    endtask

    initial begin
        int n0, r0, w0, l0, s0, k;
        #3;
        chk("rst_cmd_valid", 128'(mem_cmd_valid), 128'(0));
        chk("rst_resp_valid", 128'(resp_axis_valid), 128'(0));
        chk("rst_resp_tuser", 128'(resp_axis_tuser), 128'(0));
        chk("rst_err", 128'(err_count_out), 128'(0));
        repeat (2) @(negedge clk_in);
        rst_in = 1'b1;
        @(negedge clk_in);

        // Write burst of 4 at 0x100
        exp_burst(1, 27'h100, 4, 128'hA000);
        send(1, hdr(27'h100, 27'd4, 1'b1));
        for (int i = 0; i < 4; i++) send(0, 128'hA000 + 128'(i));
        mem_cmd_ready = 1'b0;
        #4;
        chk("idle_after_write", 128'(req_axis_ready), 128'(1));
        @(negedge clk_in);
        mem_cmd_ready = 1'b1;
        chk("write_count", 128'(n_wr), 128'(4));
        chk("write_pending", 128'(exp_cmd.size()), 128'(0));

        // Read burst of 4 at 0x200
        n0 = nrd; r0 = nresp; l0 = n_last;
        exp_burst(0, 27'h200, 4, '0);
        send(1, hdr(27'h200, 27'd4, 1'b0));
        wait_quiet(100);
        chk("read4_cmds", 128'(nrd - n0), 128'(4));
        chk("read4_resps", 128'(nresp - r0), 128'(4));
        chk("read4_last_pos", 128'(last_idx - r0), 128'(4));
        chk("read4_last_cnt", 128'(n_last - l0), 128'(1));

        // New write header accepted while read data sits in the FIFO
        resp_axis_ready = 1'b0;
        exp_burst(0, 27'h280, 4, '0);
        send(1, hdr(27'h280, 27'd4, 1'b0));
        repeat (10) @(negedge clk_in);
        w0 = n_wr;
        exp_burst(1, 27'h2A0, 2, 128'hB000);
        send(1, hdr(27'h2A0, 27'd2, 1'b1));
        send(0, 128'hB000); send(0, 128'hB001);
        @(negedge clk_in);
        chk("drain_writes", 128'(n_wr - w0), 128'(2));
        chk("drain_held", 128'(exp_resp.size()), 128'(4));
        resp_axis_ready = 1'b1;
        wait_quiet(100);

        // Long read against a stalled response stream
        n0 = nrd; r0 = nresp;
        resp_axis_ready = 1'b0;
        exp_burst(0, 27'h300, 20, '0);
        send(1, hdr(27'h300, 27'd20, 1'b0));
        repeat (40) @(negedge clk_in);
        chk("stall_cmds", 128'(nrd - n0), 128'(8));
        resp_axis_ready = 1'b1;
        wait_quiet(300);
        chk("long_cmds", 128'(nrd - n0), 128'(20));
        chk("long_resps", 128'(nresp - r0), 128'(20));

        // IDLE data beat, then header mid-write
        send(0, 128'h1234);
        w0 = n_wr;
        exp_burst(1, 27'h400, 2, 128'hC000);
        exp_burst(1, 27'h500, 2, 128'hD000);
        send(1, hdr(27'h400, 27'd4, 1'b1));
        send(0, 128'hC000); send(0, 128'hC001);
        @(negedge clk_in);
        chk("trunc_writes", 128'(n_wr - w0), 128'(2));
        send(1, hdr(27'h500, 27'd2, 1'b1));
        send(0, 128'hD000); send(0, 128'hD001);
        wait_quiet(50);
        chk("err_after_trunc", 128'(err_count_out), 128'(2));
        chk("trunc_total", 128'(n_wr - w0), 128'(4));

        // Address wrap
        exp_cmd.push_back('{1'b1, 27'h7FFFFFE, 128'hE0, 1'b0});
        exp_cmd.push_back('{1'b1, 27'h7FFFFFF, 128'hE1, 1'b0});
        exp_cmd.push_back('{1'b1, 27'h0000000, 128'hE2, 1'b0});
        exp_cmd.push_back('{1'b1, 27'h0000001, 128'hE3, 1'b1});
        send(1, hdr(27'h7FFFFFE, 27'd4, 1'b1));
        for (int i = 0; i < 4; i++) send(0, 128'hE0 + 128'(i));
        wait_quiet(50);
        chk("wrap_pending", 128'(exp_cmd.size()), 128'(0));

        // Zero-length header issues nothing
        n0 = nrd; w0 = n_wr;
        send(1, hdr(27'h700, 27'd0, 1'b0));
        repeat (5) @(negedge clk_in);
        chk("len0_cmds", 128'(nrd + n_wr - n0 - w0), 128'(0));
        chk("len0_err", 128'(err_count_out), 128'(2));

        // Reset during a read burst
        n0 = nrd;
        exp_burst(0, 27'h600, 4, '0);
        send(1, hdr(27'h600, 27'd4, 1'b0));
        k = 0;
        while (nrd < n0 + 2 && k < 50) begin @(negedge clk_in); k++; end
        chk("rst_wait", 128'(nrd - n0), 128'(2));
        #2;
        rst_in = 1'b0;
        exp_cmd.delete();
        exp_resp.delete();
        foreach (mq[i]) mq[i].stray = 1'b1;
        #1;
        chk("mid_rst_cmd_valid", 128'(mem_cmd_valid), 128'(0));
        chk("mid_rst_resp_valid", 128'(resp_axis_valid), 128'(0));
        chk("mid_rst_tuser", 128'(resp_axis_tuser), 128'(0));
        chk("mid_rst_err", 128'(err_count_out), 128'(0));
        chk("mid_rst_ready", 128'(req_axis_ready), 128'(1));
        s0 = stray_seen;
        @(negedge clk_in);
        rst_in = 1'b1;
        wait_quiet(50);
        chk("stray_returns", 128'(stray_seen - s0), 128'(2));
        chk("stray_err", 128'(err_count_out), 128'(2));
        n0 = nrd; r0 = nresp;
        exp_burst(0, 27'h610, 2, '0);
        send(1, hdr(27'h610, 27'd2, 1'b0));
        wait_quiet(100);
        chk("post_rst_reads", 128'(nresp - r0), 128'(2));
        chk("post_rst_err", 128'(err_count_out), 128'(2));

        // Saturation of the error counter
        for (int i = 0; i < 100; i++) send(0, 128'(i));
        @(negedge clk_in);
        chk("err_102", 128'(err_count_out), 128'(102));
        for (int i = 0; i < 160; i++) send(0, 128'(i));
        @(negedge clk_in);
        chk("err_sat", 128'(err_count_out), 128'hFF);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
